// File: rtl/sif_mult_half_fp_arb.sv
// sif_mult_half_fp_arb: round-robin arbiter sharing one fp16 multiplier among NUM_REQ requesters
module sif_mult_half_fp_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_dat,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_dat,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic [DATA_W-1:0]         rsp_dat,
    input  logic [NUM_REQ-1:0]        rsp_rdy,
    output logic                      mul_A_vld,
    output logic [DATA_W-1:0]         mul_A_dat,
    input  logic                      mul_A_rdy,
    output logic                      mul_B_vld,
    output logic [DATA_W-1:0]         mul_B_dat,
    input  logic                      mul_B_rdy,
    input  logic                      mul_P_vld,
    input  logic [DATA_W-1:0]         mul_P_dat,
    output logic                      mul_P_rdy,
    output logic                      busy,
    output logic                      err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int FW = $clog2(MAX_OUT);

    logic [PW-1:0] ptr, gnt_idx, head;
    logic [PW-1:0] tag_mem [MAX_OUT];
    logic [PW:0]   cand;
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] outstanding;
    logic          gnt_any, a_pend, b_pend, can_acc, accept, fifo_empty, pop;

    // Reverse scan so the nearest requester after ptr is the last one written.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            cand = (cand >= (PW+1)'(NUM_REQ)) ? cand - (PW+1)'(NUM_REQ) : cand;
            if (req_vld[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    assign can_acc    = (~a_pend | mul_A_rdy) & (~b_pend | mul_B_rdy) & (outstanding < OW'(MAX_OUT));
    assign accept     = gnt_any & can_acc;
    assign req_rdy    = accept ? NUM_REQ'(1) << gnt_idx : '0;
    assign mul_A_vld  = a_pend;
    assign mul_B_vld  = b_pend;
    assign fifo_empty = outstanding == '0;
    assign head       = tag_mem[rd_ptr];
    assign rsp_vld    = (mul_P_vld & ~fifo_empty) ? NUM_REQ'(1) << head : '0;
    assign rsp_dat    = mul_P_dat;
    assign mul_P_rdy  = fifo_empty | rsp_rdy[head];
    assign pop        = mul_P_vld & ~fifo_empty & rsp_rdy[head];
    assign busy       = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            a_pend      <= 1'b0;
            b_pend      <= 1'b0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err         <= 1'b0;
        end else begin
            if (accept) ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            a_pend      <= accept | (a_pend & ~mul_A_rdy);
            b_pend      <= accept | (b_pend & ~mul_B_rdy);
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            outstanding <= outstanding + OW'(accept) - OW'(pop);
            // A product with no owner is a leftover from before a reset: drain it and flag.
            if (mul_P_vld & fifo_empty) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mul_A_dat       <= req_a_dat[gnt_idx*DATA_W +: DATA_W];
            mul_B_dat       <= req_b_dat[gnt_idx*DATA_W +: DATA_W];
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end
endmodule

// File: tb/tb_sif_mult_half_fp_arb.sv
// tb_sif_mult_half_fp_arb: randomized and directed bench with a queue-based reference model
module tb_sif_mult_half_fp_arb;
    localparam int N = 4, W = 16, MO = 8, LAT = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [N*W-1:0] req_a_dat, req_b_dat;
    logic [W-1:0] rsp_dat, mul_A_dat, mul_B_dat, mul_P_dat;
    logic mul_A_vld, mul_A_rdy, mul_B_vld, mul_B_rdy, mul_P_vld, mul_P_rdy, busy, err;

    always #5 clk = ~clk;

    sif_mult_half_fp_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_OUT(MO)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_a_dat(req_a_dat), .req_b_dat(req_b_dat),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_dat(rsp_dat), .rsp_rdy(rsp_rdy),
        .mul_A_vld(mul_A_vld), .mul_A_dat(mul_A_dat), .mul_A_rdy(mul_A_rdy),
        .mul_B_vld(mul_B_vld), .mul_B_dat(mul_B_dat), .mul_B_rdy(mul_B_rdy),
        .mul_P_vld(mul_P_vld), .mul_P_dat(mul_P_dat), .mul_P_rdy(mul_P_rdy),
        .busy(busy), .err(err)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit chk_en = 1'b0;
    // reference model: round-robin pointer, issue flags, tag/product FIFO
    int m_ptr = 0;
    bit m_a_pend = 1'b0, m_b_pend = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_a_dat, m_b_dat;
    int m_tag[$];
    logic [W-1:0] m_prod[$];
    // multiplier environment
    logic [W-1:0] a_q[$], b_q[$], p_v[$];
    int p_t[$];
    // observations
    int n_acc = 0, n_rsp = 0, last_rsp_cyc = 0, rsp_seen = 0;
    int gq[$];
    logic [N-1:0] last_rdy, last_rsp_vld;
    logic [W-1:0] last_rsp_dat;
    logic last_a_vld, last_busy, last_err;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int dec(logic [15:0] h);
        int n;
        n = (1024 + int'(h[9:0])) >> (25 - int'(h[14:10]));
        return h[15] ? -n : n;
    endfunction

    function automatic logic [15:0] enc(int v);
        int n, e;
        n = v < 0 ? -v : v;
        e = 0;
        for (int i = 0; i < 16; i++) if ((n >> i) != 0) e = i;
        return {v < 0, 5'(e + 15), 10'((n << (10 - e)) & 'h3ff)};
    endfunction

    function automatic logic [15:0] fmul(logic [15:0] a, logic [15:0] b);
        return enc(dec(a) * dec(b));
    endfunction

    function automatic logic [15:0] rand_op();
        return enc(int'($urandom_range(1, 15)) * ($urandom_range(0, 1) != 0 ? -1 : 1));
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a_dat[i*W +: W] = rand_op();
            req_b_dat[i*W +: W] = rand_op();
        end
    endtask

    task automatic step();
        int g;
        bit can, acc, pop;
        logic [N-1:0] e_rdy, e_rsp;
        logic e_prdy;
        mul_P_vld = p_v.size() > 0 && p_t[0] <= cyc;
        mul_P_dat = p_v.size() > 0 ? p_v[0] : '0;
        @(negedge clk);
        can = (!m_a_pend || mul_A_rdy) && (!m_b_pend || mul_B_rdy) && m_tag.size() < MO;
        g = -1;
        for (int k = 0; k < N; k++) if (g < 0 && req_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        acc    = can && g >= 0;
        e_rdy  = acc ? N'(1) << g : '0;
        e_prdy = m_tag.size() == 0 ? 1'b1 : rsp_rdy[m_tag[0]];
        e_rsp  = (mul_P_vld && m_tag.size() > 0) ? N'(1) << m_tag[0] : '0;
        if (chk_en) begin
            check("req_rdy", 32'(req_rdy), 32'(e_rdy));
            check("mul_A_vld", 32'(mul_A_vld), 32'(m_a_pend));
            check("mul_B_vld", 32'(mul_B_vld), 32'(m_b_pend));
            if (m_a_pend) check("mul_A_dat", 32'(mul_A_dat), 32'(m_a_dat));
            if (m_b_pend) check("mul_B_dat", 32'(mul_B_dat), 32'(m_b_dat));
            check("rsp_vld", 32'(rsp_vld), 32'(e_rsp));
            if (e_rsp != 0) check("rsp_dat", 32'(rsp_dat), 32'(m_prod[0]));
            check("mul_P_rdy", 32'(mul_P_rdy), 32'(e_prdy));
            check("busy", 32'(busy), 32'(m_tag.size() != 0));
            check("err", 32'(err), 32'(m_err));
        end
        for (int k = 0; k < N; k++) if (req_vld[k] && req_rdy[k]) begin n_acc++; gq.push_back(k); end
        if ((rsp_vld & rsp_rdy) != 0) begin n_rsp++; last_rsp_cyc = cyc; end
        if (rsp_vld != 0) begin rsp_seen++; last_rsp_vld = rsp_vld; last_rsp_dat = rsp_dat; end
        last_rdy = req_rdy; last_a_vld = mul_A_vld; last_busy = busy; last_err = err;
        if (mul_P_vld && mul_P_rdy) begin void'(p_v.pop_front()); void'(p_t.pop_front()); end
        if (mul_A_vld && mul_A_rdy) a_q.push_back(mul_A_dat);
        if (mul_B_vld && mul_B_rdy) b_q.push_back(mul_B_dat);
        while (a_q.size() > 0 && b_q.size() > 0) begin
            p_v.push_back(fmul(a_q.pop_front(), b_q.pop_front()));
            p_t.push_back(cyc + LAT);
        end
        pop = mul_P_vld && e_prdy && m_tag.size() > 0;
        if (rst) begin
            a_q.delete(); b_q.delete();
            m_ptr = 0; m_a_pend = 0; m_b_pend = 0; m_err = 0;
            m_tag.delete(); m_prod.delete();
        end else begin
            if (mul_P_vld && m_tag.size() == 0) m_err = 1;
            if (pop) begin void'(m_tag.pop_front()); void'(m_prod.pop_front()); end
            m_a_pend = acc || (m_a_pend && !mul_A_rdy);
            m_b_pend = acc || (m_b_pend && !mul_B_rdy);
            if (acc) begin
                m_a_dat = req_a_dat[g*W +: W];
                m_b_dat = req_b_dat[g*W +: W];
                m_tag.push_back(g);
                m_prod.push_back(fmul(m_a_dat, m_b_dat));
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        repeat (n) begin rand_ops(); step(); end
    endtask

    initial begin
        int base, rbase, c0;
        rst = 1; req_vld = '0; rsp_rdy = '0; mul_A_rdy = 1; mul_B_rdy = 1;
        req_a_dat = '0; req_b_dat = '0;
        run(3);
        rst = 0; chk_en = 1;
        // burst: all requesters, 16 operations
        rsp_rdy = '1; req_vld = '1; base = n_acc; rbase = n_rsp; c0 = cyc; gq.delete();
        for (int i = 0; i < 40 && n_acc - base < 16; i++) run(1);
        req_vld = '0;
        for (int i = 0; i < 40 && n_rsp - rbase < 16; i++) run(1);
        check("burst_rsp", 32'(n_rsp - rbase), 32'd16);
        check("burst_cycles", 32'(last_rsp_cyc - c0 + 1), 32'(16 + LAT + 1));
        for (int i = 0; i < 16; i++) check("burst_order", 32'(i < gq.size() ? gq[i] : -1), 32'(i % N));
        run(4);
        // single requester 2: 2.0 * 3.0
        req_vld = 4'b0100;
        req_a_dat[2*W +: W] = 16'h4000;
        req_b_dat[2*W +: W] = 16'h4200;
        step();
        check("single_rdy", 32'(last_rdy), 32'h4);
        req_vld = '0; rsp_seen = 0;
        for (int i = 0; i < 12 && rsp_seen == 0; i++) run(1);
        check("single_rsp_vld", 32'(last_rsp_vld), 32'h4);
        check("single_rsp_dat", 32'(last_rsp_dat), 32'h4600);
        run(2);
        check("single_idle", 32'(last_busy), 32'd0);
        // skewed A/B handshake
        req_vld = 4'b0001; run(1);
        req_vld = '1; mul_B_rdy = 0; base = n_acc;
        run(3);
        check("skew_no_grant", 32'(n_acc - base), 32'd0);
        check("skew_a_dropped", 32'(last_a_vld), 32'd0);
        mul_B_rdy = 1; run(1);
        check("skew_resume", 32'(n_acc - base), 32'd1);
        req_vld = '0; run(12);
        // credit limit
        rsp_rdy = '0; req_vld = '1; base = n_acc;
        run(15);
        check("credit_grants", 32'(n_acc - base), 32'(MO));
        check("credit_rdy", 32'(last_rdy), 32'd0);
        rsp_rdy = '1; run(10);
        req_vld = '0; run(20);
        check("credit_idle", 32'(last_busy), 32'd0);
        // simultaneous grant and return at 7 outstanding
        rsp_rdy = '0; req_vld = '1; base = n_acc;
        for (int i = 0; i < 20 && n_acc - base < 7; i++) run(1);
        req_vld = '0; run(6);
        rsp_rdy = '1; req_vld = 4'b0010; base = n_acc; rbase = n_rsp;
        run(1);
        check("sim_grant", 32'(n_acc - base), 32'd1);
        check("sim_return", 32'(n_rsp - rbase), 32'd1);
        rsp_rdy = '0; req_vld = '1; base = n_acc;
        run(6);
        check("sim_one_credit", 32'(n_acc - base), 32'd1);
        rsp_rdy = '1; req_vld = '0; run(20);
        // reset with 5 operations in flight
        rsp_rdy = '0; req_vld = '1; base = n_acc;
        for (int i = 0; i < 20 && n_acc - base < 5; i++) run(1);
        req_vld = '0; run(6);
        rst = 1; run(1);
        rst = 0; run(1);
        check("rst_busy", 32'(last_busy), 32'd0);
        check("rst_a_vld", 32'(last_a_vld), 32'd0);
        check("rst_err", 32'(last_err), 32'd0);
        rsp_seen = 0;
        repeat (10) begin rsp_rdy = N'($urandom); run(1); end
        check("stale_rsp_vld", 32'(rsp_seen), 32'd0);
        check("stale_err", 32'(last_err), 32'd1);
        check("stale_drained", 32'(p_v.size()), 32'd0);
        // random traffic
        repeat (3000) begin
            req_vld = N'($urandom);
            rsp_rdy = N'($urandom);
            mul_A_rdy = $urandom_range(0, 3) != 0;
            mul_B_rdy = $urandom_range(0, 3) != 0;
            run(1);
        end
        req_vld = '0; rsp_rdy = '1; mul_A_rdy = 1; mul_B_rdy = 1;
        run(30);
        check("final_idle", 32'(last_busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
